// File: rtl/conv_line_buffer_sequencer.sv
// Sequences the raster feature stream into the row shift register and flags completed 3x3 windows.
// Optional LINE_BUFFER_WINDOW_COUNT_EN adds a per-frame window_cnt output.
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

module conv_line_buffer_sequencer #(
  parameter int FEATURE_WIDTH = `FEATURE_WIDTH,
  parameter int SHIFT_ADJ     = 2,
  parameter int KERNEL        = 3
) (
  input  logic                       system_clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [9:0]                 row_size,
  input  logic [9:0]                 col_size,
  input  logic                       in_valid,
  input  logic [2*FEATURE_WIDTH-1:0] in_data,
  output logic                       in_ready,
  output logic                       sr_wr_en,
  output logic [2*FEATURE_WIDTH-1:0] sr_wr_data,
  output logic [9:0]                 sr_shift_size,
  output logic                       window_valid,
  output logic [9:0]                 win_row,
  output logic [9:0]                 win_col,
  output logic                       busy,
  output logic                       done,
`ifdef LINE_BUFFER_WINDOW_COUNT_EN
  output logic [19:0]                window_cnt,
`endif
  output logic                       cfg_err
);

  // state   | meaning
  // IDLE    | waiting for start
  // RUN     | accepting samples
  // FLUSH   | last sample accepted, letting the final window drain
  // DONE    | one-cycle done pulse
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [9:0] K_MIN  = 10'(KERNEL);
  localparam logic [9:0] K_LAST = 10'(KERNEL - 1);
  localparam logic [9:0] ADJ    = 10'(SHIFT_ADJ);

  logic [1:0] state;
  logic [9:0] row_lat, col_lat;
  logic [9:0] row, col;
  logic [9:0] s1_row, s1_col;
  logic       s1_win;
  logic       accept, last_col, last_sample, size_ok;

  assign accept      = in_valid & in_ready;
  assign last_col    = (col == row_lat - 10'd1);
  assign last_sample = last_col && (row == col_lat - 10'd1);
  assign size_ok     = (row_size >= K_MIN) && (col_size >= K_MIN);

  always_comb begin
    in_ready = (state == S_RUN);
    busy     = (state == S_RUN) || (state == S_FLUSH);
    done     = (state == S_DONE);
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      row_lat       <= '0;
      col_lat       <= '0;
      row           <= '0;
      col           <= '0;
      sr_shift_size <= '0;
      cfg_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            row_lat <= row_size;
            col_lat <= col_size;
            row     <= '0;
            col     <= '0;
            if (!size_ok) begin
              cfg_err <= 1'b1;
              state   <= S_DONE;
            end else begin
              cfg_err       <= 1'b0;
              sr_shift_size <= row_size - ADJ;
              state         <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            if (last_col) begin
              col <= '0;
              row <= row + 10'd1;
            end else begin
              col <= col + 10'd1;
            end
            if (last_sample) state <= S_FLUSH;
          end
        end
        S_FLUSH: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-stage pipe: write stage, then window flag aligned with the datapath.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_wr_en     <= 1'b0;
      sr_wr_data   <= '0;
      s1_row       <= '0;
      s1_col       <= '0;
      s1_win       <= 1'b0;
      window_valid <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
    end else begin
      sr_wr_en <= accept;
      if (accept) begin
        sr_wr_data <= in_data;
        s1_row     <= row;
        s1_col     <= col;
        s1_win     <= (row >= K_LAST) && (col >= K_LAST);
      end
      window_valid <= sr_wr_en & s1_win;
      if (sr_wr_en && s1_win) begin
        win_row <= s1_row;
        win_col <= s1_col;
      end
    end
  end

`ifdef LINE_BUFFER_WINDOW_COUNT_EN
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n)
      window_cnt <= '0;
    else if ((state == S_IDLE) && start && size_ok)
      window_cnt <= '0;
    else if (window_valid)
      window_cnt <= window_cnt + 20'd1;
  end
`endif

endmodule

// File: tb/tb_conv_line_buffer_sequencer.sv
// Directed bench for conv_line_buffer_sequencer; covers window_cnt when LINE_BUFFER_WINDOW_COUNT_EN is defined.
module tb_conv_line_buffer_sequencer;
  localparam int FW = 8;
  localparam int DW = 2 * FW;

  logic          system_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [9:0]    row_size = '0;
  logic [9:0]    col_size = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, sr_wr_en, window_valid, busy, done, cfg_err;
  logic [DW-1:0] sr_wr_data;
  logic [9:0]    sr_shift_size, win_row, win_col;
`ifdef LINE_BUFFER_WINDOW_COUNT_EN
  logic [19:0]   window_cnt;
`endif

  conv_line_buffer_sequencer #(.FEATURE_WIDTH(FW)) dut (
    .system_clk(system_clk), .rst_n(rst_n), .start(start),
    .row_size(row_size), .col_size(col_size),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sr_wr_en(sr_wr_en), .sr_wr_data(sr_wr_data), .sr_shift_size(sr_shift_size),
    .window_valid(window_valid), .win_row(win_row), .win_col(win_col),
    .busy(busy), .done(done),
`ifdef LINE_BUFFER_WINDOW_COUNT_EN
    .window_cnt(window_cnt),
`endif
    .cfg_err(cfg_err)
  );

  always #5 system_clk = ~system_clk;

  int n_checks = 0;
  int n_pass = 0;
  int acc_cyc[$], wr_cyc[$], win_cyc[$], win_r[$], win_c[$], done_cyc[$];
  logic [DW-1:0] acc_data[$], wr_data[$];
  int ready_seen;

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Runs one frame from a start pulse; cycle n = n-th falling edge after the start edge.
  task automatic run_frame(input int rs, input int cs, input bit toggle,
                           input int stray_at, input int stop_acc, input int max_cyc);
    int cyc, sent;
    acc_cyc.delete(); acc_data.delete(); wr_cyc.delete(); wr_data.delete();
    win_cyc.delete(); win_r.delete(); win_c.delete(); done_cyc.delete();
    ready_seen = 0;
    sent = 0;
    @(negedge system_clk);
    row_size = 10'(rs); col_size = 10'(cs); start = 1'b1; in_valid = 1'b0;
    cyc = 0;
    while (cyc < max_cyc) begin
      @(negedge system_clk);
      cyc++;
      start = 1'b0; row_size = 10'(rs); col_size = 10'(cs);
      if (in_ready) ready_seen++;
      if (sr_wr_en) begin wr_cyc.push_back(cyc); wr_data.push_back(sr_wr_data); end
      if (window_valid) begin
        win_cyc.push_back(cyc); win_r.push_back(int'(win_row)); win_c.push_back(int'(win_col));
      end
      if (done) begin done_cyc.push_back(cyc); in_valid = 1'b0; break; end
      if (cyc == stray_at) begin start = 1'b1; row_size = 10'd7; col_size = 10'd9; end
      in_valid = (sent < rs * cs) && (!toggle || (cyc % 2 == 1));
      in_data = DW'(sent);
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc); acc_data.push_back(in_data); sent++;
        if (sent == stop_acc) break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge system_clk);
    n_checks++;
    if ({in_ready, sr_wr_en, sr_wr_data, sr_shift_size, window_valid, win_row, win_col, busy, done, cfg_err} !== '0)
      $display("FAIL reset_outputs: got ready=%b wr=%b ssz=%0d wv=%b busy=%b done=%b err=%b, expected all 0",
               in_ready, sr_wr_en, sr_shift_size, window_valid, busy, done, cfg_err);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_continuous();
    int exp_r[4] = '{2, 2, 3, 3};
    int exp_c[4] = '{2, 3, 2, 3};
    int bad;
    run_frame(4, 4, 1'b0, -1, -1, 60);
    n_checks++;
    if (sr_shift_size !== 10'd2) $display("FAIL cont_shift_size: got %0d expected 2", sr_shift_size);
    else n_pass++;
    n_checks++;
    if (win_cyc.size() != 4) $display("FAIL cont_window_count: got %0d expected 4", win_cyc.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (qget(win_r, i) != exp_r[i] || qget(win_c, i) != exp_c[i]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL cont_window_coords: %0d wrong coordinate pairs, expected 0", bad);
    else n_pass++;
    n_checks++;
    if (qget(win_cyc, 0) != qget(acc_cyc, 10) + 2 || qget(acc_cyc, 10) != 11)
      $display("FAIL cont_first_window_cycle: got %0d expected %0d", qget(win_cyc, 0), 13);
    else n_pass++;
    n_checks++;
    if (qget(done_cyc, 0) != 18) $display("FAIL cont_done_cycle: got %0d expected 18", qget(done_cyc, 0));
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (qget(wr_cyc, i) != qget(acc_cyc, i) + 1 || i >= wr_data.size() || wr_data[i] !== DW'(i)) bad++;
    n_checks++;
    if (bad != 0 || wr_cyc.size() != 16)
      $display("FAIL cont_write_stream: %0d bad writes, count %0d, expected 0 bad and 16", bad, wr_cyc.size());
    else n_pass++;
  endtask

  task automatic test_bubbles();
    int exp_k[4] = '{10, 11, 14, 15};
    int bad;
    run_frame(4, 4, 1'b1, -1, -1, 80);
    n_checks++;
    if (wr_cyc.size() != 16) $display("FAIL bub_wr_count: got %0d expected 16", wr_cyc.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (qget(wr_cyc, i) != qget(acc_cyc, i) + 1) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL bub_wr_timing: %0d writes off the accept+1 slot, expected 0", bad);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (qget(win_cyc, i) != qget(acc_cyc, exp_k[i]) + 2 ||
          qget(win_r, i) != exp_k[i] / 4 || qget(win_c, i) != exp_k[i] % 4) bad++;
    n_checks++;
    if (bad != 0 || win_cyc.size() != 4)
      $display("FAIL bub_windows: %0d bad, count %0d, expected 0 bad and 4", bad, win_cyc.size());
    else n_pass++;
  endtask

  task automatic test_cfg_err();
    run_frame(2, 8, 1'b0, -1, -1, 20);
    n_checks++;
    if (cfg_err !== 1'b1) $display("FAIL cfg_err_set: got %b expected 1", cfg_err);
    else n_pass++;
    n_checks++;
    if (qget(done_cyc, 0) != 1) $display("FAIL cfg_done_cycle: got %0d expected 1", qget(done_cyc, 0));
    else n_pass++;
    n_checks++;
    if (ready_seen != 0 || wr_cyc.size() != 0)
      $display("FAIL cfg_no_traffic: ready cycles %0d writes %0d, expected 0 and 0", ready_seen, wr_cyc.size());
    else n_pass++;
    n_checks++;
    if (sr_shift_size !== 10'd2) $display("FAIL cfg_shift_held: got %0d expected 2", sr_shift_size);
    else n_pass++;
    // smallest legal frame clears the sticky error
    run_frame(3, 3, 1'b0, -1, -1, 40);
    n_checks++;
    if (cfg_err !== 1'b0 || sr_shift_size !== 10'd1)
      $display("FAIL cfg_min_frame: err=%b ssz=%0d, expected err=0 ssz=1", cfg_err, sr_shift_size);
    else n_pass++;
    n_checks++;
    if (win_cyc.size() != 1 || qget(win_r, 0) != 2 || qget(win_c, 0) != 2 || qget(done_cyc, 0) != 11)
      $display("FAIL cfg_min_windows: count %0d first (%0d,%0d) done %0d, expected 1 (2,2) 11",
               win_cyc.size(), qget(win_r, 0), qget(win_c, 0), qget(done_cyc, 0));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dones;
    run_frame(4, 4, 1'b0, -1, 7, 40);
    @(posedge system_clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, sr_wr_en, sr_wr_data, sr_shift_size, window_valid, win_row, win_col, busy, done, cfg_err} !== '0)
      $display("FAIL midreset_outputs: got ready=%b wr=%b data=%0d ssz=%0d busy=%b, expected all 0",
               in_ready, sr_wr_en, sr_wr_data, sr_shift_size, busy);
    else n_pass++;
    @(negedge system_clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge system_clk);
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones != 0) $display("FAIL midreset_no_done: got %0d done/busy cycles expected 0", dones);
    else n_pass++;
    run_frame(4, 4, 1'b0, -1, -1, 60);
    n_checks++;
    if (win_cyc.size() != 4 || qget(done_cyc, 0) != 18)
      $display("FAIL midreset_clean_frame: windows %0d done %0d, expected 4 and 18", win_cyc.size(), qget(done_cyc, 0));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_frame(4, 4, 1'b0, 5, -1, 60);
    n_checks++;
    if (win_cyc.size() != 4 || qget(win_r, 3) != 3 || qget(win_c, 3) != 3 || qget(done_cyc, 0) != 18)
      $display("FAIL stray_start_frame: windows %0d last (%0d,%0d) done %0d, expected 4 (3,3) 18",
               win_cyc.size(), qget(win_r, 3), qget(win_c, 3), qget(done_cyc, 0));
    else n_pass++;
    n_checks++;
    if (sr_shift_size !== 10'd2) $display("FAIL stray_start_shift: got %0d expected 2", sr_shift_size);
    else n_pass++;
    run_frame(5, 4, 1'b0, -1, -1, 60);
    n_checks++;
    if (qget(acc_cyc, 0) != 1 || acc_cyc.size() != 20 || qget(done_cyc, 0) != 22)
      $display("FAIL b2b_frame_timing: first acc %0d accepts %0d done %0d, expected 1 20 22",
               qget(acc_cyc, 0), acc_cyc.size(), qget(done_cyc, 0));
    else n_pass++;
    n_checks++;
    if (win_cyc.size() != 6 || qget(win_r, 0) != 2 || qget(win_c, 2) != 4 || qget(win_r, 5) != 3 ||
        sr_shift_size !== 10'd3 || cfg_err !== 1'b0)
      $display("FAIL b2b_windows: count %0d ssz %0d err %b, expected 6 3 0", win_cyc.size(), sr_shift_size, cfg_err);
    else n_pass++;
  endtask

`ifdef LINE_BUFFER_WINDOW_COUNT_EN
  task automatic test_window_count();
    run_frame(5, 6, 1'b0, -1, -1, 80);
    @(negedge system_clk);
    n_checks++;
    if (window_cnt !== 20'd12 || win_cyc.size() != 12)
      $display("FAIL window_cnt_5x6: got cnt %0d pulses %0d expected 12 and 12", window_cnt, win_cyc.size());
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_bubbles();
    test_cfg_err();
    test_reset_mid();
    test_back_to_back();
`ifdef LINE_BUFFER_WINDOW_COUNT_EN
    test_window_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
